mp_adder_seq: RTL and testbench



---
 rtl/mp_adder_seq.sv | 121 ++++++++++++
 tb/tb_mp_adder_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_adder_seq.sv
// mp_adder_seq: NWORDS x 16-bit add/sub over one shared 16-bit ripple adder.
// Define MP_ADDER_OVF_EN to add the signed-overflow output ovf.
module ripple_carry_adder_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);
    logic [16:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[16];
endmodule

module mp_adder_seq #(
    parameter int NWORDS = 4,
    localparam int W = 16 * NWORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         sub,
    input  logic         cin,
    output logic [W-1:0] res,
    output logic         cout,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef MP_ADDER_OVF_EN
    output logic         ovf,
`endif
    output logic         busy
);
    localparam int IW = $clog2(NWORDS);
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          carry;
    logic [IW-1:0] idx;
    logic [15:0]   wa;
    logic [15:0]   wb;
    logic [15:0]   sum;
    logic          co;

    assign wa       = a_reg[idx*16 +: 16];
    assign wb       = b_reg[idx*16 +: 16];
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    ripple_carry_adder_16 u_add (
        .a  (wa),
        .b  (wb),
        .ci (carry),
        .s  (sum),
        .co (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            res       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef MP_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= op_a;
                        b_reg <= sub ? ~op_b : op_b;
                        carry <= sub | cin;
                        idx   <= '0;
                        res   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res[idx*16 +: 16] <= sum;
                    carry <= co;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout      <= co;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef MP_ADDER_OVF_EN
                        // sum[15] here is the final result's sign bit
                        ovf <= (a_reg[W-1] == b_reg[W-1])
                            && (sum[15] != a_reg[W-1]);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mp_adder_seq.sv
// tb_mp_adder_seq: random and directed checks of mp_adder_seq against
// a whole-word arithmetic model of the sequencer.
module tb_mp_adder_seq;
    localparam int NWORDS = 4;
    localparam int W = 16 * NWORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         in_ready;
    logic         cout;
    logic         out_valid;
    logic         busy;
    logic [W-1:0] res;
`ifdef MP_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mp_adder_seq #(.NWORDS(NWORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .cin       (cin),
        .res       (res),
        .cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef MP_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 computing (counts edges left), 2 holding result
    int           m_st = 0;
    int           m_cnt = 0;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_res = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;
    logic [W:0]   m_pend;
    logic         m_povf;
    logic [W-1:0] m_bp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st    <= 0;
            m_cnt   <= 0;
            m_valid <= 1'b0;
            m_res   <= '0;
            m_cout  <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (m_st == 0) begin
            if (in_valid) begin
                m_bp   = sub ? ~op_b : op_b;
                m_pend = {1'b0, op_a} + {1'b0, m_bp} + (W+1)'(sub ? 1'b1 : cin);
                m_povf = (op_a[W-1] == m_bp[W-1]) && (m_pend[W-1] != op_a[W-1]);
                m_res  <= '0;
                m_cnt  <= NWORDS;
                m_st   <= 1;
            end
        end else if (m_st == 1) begin
            if (m_cnt == 1) begin
                m_st    <= 2;
                m_valid <= 1'b1;
                m_res   <= m_pend[W-1:0];
                m_cout  <= m_pend[W];
                m_ovf   <= m_povf;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else begin
            if (out_ready) begin
                m_st    <= 0;
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk1("in_ready", in_ready, m_st == 0);
            chk1("busy", busy, m_st != 0);
            chk1("out_valid", out_valid, m_valid);
            if (m_st != 1) begin
                chkw("res", res, m_res);
                chk1("cout", cout, m_cout);
`ifdef MP_ADDER_OVF_EN
                chk1("ovf", ovf, m_ovf);
`endif
            end
        end
    end

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] v;
        int mode;
        mode = int'($urandom_range(0, 7));
        for (int i = 0; i < NWORDS; i++)
            v[i*16 +: 16] = 16'($urandom);
        if (mode == 0) v = '1;
        if (mode == 1) v = '0;
        if (mode == 2) v[W-1] = ~v[W-1];
        return v;
    endfunction

    task automatic do_op(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic s, input logic c,
                         input int hold, input logic lit,
                         input logic [W-1:0] er, input logic ec,
                         input logic eo);
        int n;
        int lat;
        logic [W-1:0] r0;
        op_a = a;
        op_b = b;
        sub = s;
        cin = c;
        out_ready = (hold == 0);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a = rnd_word();
        op_b = rnd_word();
        sub = 1'($urandom);
        cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chki({tag, "_latency"}, lat, NWORDS);
        r0 = res;
        if (lit) begin
            chkw({tag, "_res"}, res, er);
            chk1({tag, "_cout"}, cout, ec);
`ifdef MP_ADDER_OVF_EN
            chk1({tag, "_ovf"}, ovf, eo);
`endif
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == 1) || 1'($urandom);
            op_a = rnd_word();
            op_b = rnd_word();
            @(posedge clk); #1;
            chkw({tag, "_frozen"}, res, r0);
            chk1({tag, "_noaccept"}, in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk1({tag, "_hs_valid"}, out_valid, 1'b0);
        chk1({tag, "_hs_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chkw("rst_res", res, '0);
        chk1("rst_cout", cout, 1'b0);
        chk1("rst_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk1("rst_ready", in_ready, 1'b1);

        do_op("add", 64'h1, 64'h21, 1'b0, 1'b0, 0, 1'b1,
              64'h22, 1'b0, 1'b0);
        do_op("icarry", 64'hFFFF, 64'h1, 1'b0, 1'b0, 0, 1'b1,
              64'h1_0000, 1'b0, 1'b0);
        do_op("fcarry", '1, '1, 1'b0, 1'b1, 0, 1'b1,
              '1, 1'b1, 1'b0);
        do_op("borrow", 64'h5, 64'h7, 1'b1, 1'b1, 0, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        do_op("sovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 0, 1'b1,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        do_op("bp", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
              1'b0, 1'b1, 5, 1'b1, 64'h2222_2222_2222_2212, 1'b0, 1'b0);
        do_op("rep", 64'h3, 64'h4, 1'b0, 1'b0, 0, 1'b1,
              64'h7, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++)
            do_op("rnd", rnd_word(), rnd_word(), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), 1'b0, '0, 1'b0, 1'b0);

        op_a = 64'hAAAA_AAAA_AAAA_AAAA;
        op_b = 64'h5555_5555_5555_5555;
        sub = 1'b0;
        cin = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chkw("mrst_res", res, '0);
        chk1("mrst_valid", out_valid, 1'b0);
        chk1("mrst_busy", busy, 1'b0);
        #4 rst_n = 1'b1;
        for (int i = 0; i < NWORDS + 4; i++) begin
            @(posedge clk); #1;
            chk1("mrst_nopulse", out_valid, 1'b0);
        end
        chk1("mrst_ready", in_ready, 1'b1);

        do_op("post", 64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000,
              1'b0, 1'b0, 0, 1'b1, 64'h0000_0001_0000_0000, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
